// File: rtl/key_event_controller_if.sv
// Event handshake bundle between the key debouncer (master) and the
// calculator control FSM (slave).
interface key_event_controller_if;
  logic       event_valid;
  logic       event_ready;
  logic [1:0] event_button;
  logic       overrun;
  logic       busy;

  modport master (
    output event_valid,
    output event_button,
    output overrun,
    output busy,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_button,
    input  overrun,
    input  busy,
    output event_ready
  );
endinterface

// File: rtl/key_event_controller.sv
// Debounces the four active-low front-panel keys and emits one event per
// press/release cycle over a valid/ready handshake, flagging dropped presses.
module key_event_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [3:0]                    KEY,
  key_event_controller_if.master        ev
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [3:0]           NO_KEY    = 4'b1111;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           sync1_q, sync_key_q;
  logic [3:0]           pat_q, pat_d;
  logic [1:0]           code_q, code_d;
  logic                 valid_q, valid_d;
  logic [1:0]           button_q, button_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 single_key;
  logic [1:0]           key_code;
  logic                 confirm;
  logic                 handshake;
  logic [CNT_WIDTH:0]   cnt_inc;
  logic                 cnt_reach;

  // One extra bit on the increment so the limit compare can never wrap.
  assign cnt_inc   = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign cnt_reach = (cnt_inc >= {1'b0, DEB_LIMIT});
  assign handshake = valid_q & ev.event_ready;

  always_comb begin
    single_key = 1'b1;
    key_code   = 2'd0;
    case (sync_key_q)
      4'b1110: key_code = 2'd0;
      4'b1101: key_code = 2'd1;
      4'b1011: key_code = 2'd2;
      4'b0111: key_code = 2'd3;
      default: single_key = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    code_d  = code_q;
    confirm = 1'b0;
    case (state_q)
      IDLE: begin
        if (single_key) begin
          pat_d   = sync_key_q;
          code_d  = key_code;
          cnt_d   = CNT_ONE;
          state_d = ARMING;
        end
      end
      ARMING: begin
        if (sync_key_q == pat_q) begin
          if (cnt_reach) begin
            cnt_d   = DEB_LIMIT;
            confirm = 1'b1;
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc[CNT_WIDTH-1:0];
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      PRESSED: begin
        // Any held pattern, even another key, just keeps us waiting for release.
        if (sync_key_q == NO_KEY) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASING;
        end
      end
      RELEASING: begin
        if (sync_key_q == NO_KEY) begin
          if (cnt_reach) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc[CNT_WIDTH-1:0];
          end
        end else begin
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    button_d  = button_q;
    overrun_d = 1'b0;
    if (handshake) begin
      valid_d = 1'b0;
    end
    // A handshake on the same edge frees the slot, so the new press still lands.
    if (confirm) begin
      if (!valid_q || handshake) begin
        valid_d  = 1'b1;
        button_d = code_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= NO_KEY;
      sync_key_q <= NO_KEY;
    end else begin
      sync1_q    <= KEY;
      sync_key_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= NO_KEY;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      button_q  <= 2'd0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      button_q  <= button_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign ev.event_valid  = valid_q;
  assign ev.event_button = button_q;
  assign ev.overrun      = overrun_q;
  assign ev.busy         = busy_q;

endmodule

// File: tb/tb_key_event_controller.sv
// Scoreboard bench: a rule-level key model predicts every cycle's outputs,
// a separate monitor compares them against the controller on the falling edge.
module tb_key_event_controller;

  localparam int D = 4;

  logic       clk;
  logic       resetn;
  logic [3:0] KEY;

  key_event_controller_if ev_if ();

  key_event_controller #(
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (3)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .KEY    (KEY),
    .ev     (ev_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [1:0] b;
    logic       o;
    logic       y;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the key stream is seen through a two-sample delay;
  // a press is a run of D identical single-key samples, a release a run of D idle samples.
  localparam int WAITP = 0, ARMP = 1, HELDP = 2, RELP = 3;
  logic [3:0] m_s1, m_s2, m_cand;
  int         m_phase, m_run;
  logic       m_v, m_o, m_y;
  logic [1:0] m_b;

  function automatic int nzero(input logic [3:0] k);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!k[i]) c++;
    return c;
  endfunction

  function automatic logic [1:0] code_of(input logic [3:0] k);
    logic [1:0] c = 2'd0;
    for (int i = 0; i < 4; i++) if (!k[i]) c = 2'(i);
    return c;
  endfunction

  function automatic void model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'hF;
    m_phase = WAITP; m_run = 0;
    m_v = 1'b0; m_b = 2'd0; m_o = 1'b0; m_y = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] key, input logic rdy);
    logic [3:0] sk = m_s2;
    bit confirm = 0;
    bit hs = m_v && rdy;
    exp_t e;
    m_o = 1'b0;
    if (m_phase == WAITP) begin
      if (nzero(sk) == 1) begin m_cand = sk; m_run = 1; m_phase = ARMP; end
    end else if (m_phase == ARMP) begin
      if (sk == m_cand) begin
        m_run++;
        if (m_run >= D) begin confirm = 1; m_phase = HELDP; end
      end else begin
        m_run = 0; m_phase = WAITP;
      end
    end else if (m_phase == HELDP) begin
      if (sk == 4'hF) begin m_run = 1; m_phase = RELP; end
    end else begin
      if (sk == 4'hF) begin
        m_run++;
        if (m_run >= D) begin m_run = 0; m_phase = WAITP; end
      end else begin
        m_phase = HELDP;
      end
    end
    if (hs) m_v = 1'b0;
    if (confirm) begin
      if (!m_v) begin m_v = 1'b1; m_b = code_of(m_cand); end
      else m_o = 1'b1;
    end
    m_y = (m_phase != WAITP);
    m_s2 = m_s1;
    m_s1 = key;
    e.v = m_v; e.b = m_b; e.o = m_o; e.y = m_y;
    sb.push_back(e);
  endfunction

  task automatic drive(input logic [3:0] k, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      KEY = k;
      ev_if.event_ready = r;
      @(posedge clk);
      #1;
      model_step(k, r);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"},   ev_if.event_valid,  0);
    chk({tag, "_button"},  ev_if.event_button, 0);
    chk({tag, "_overrun"}, ev_if.overrun,      0);
    chk({tag, "_busy"},    ev_if.busy,         0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero(tag);
    sb.delete();
    model_reset();
    KEY = 4'hF;
    ev_if.event_ready = 1'b0;
    @(negedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_valid",   ev_if.event_valid,  e.v);
        chk("sb_button",  ev_if.event_button, e.b);
        chk("sb_overrun", ev_if.overrun,      e.o);
        chk("sb_busy",    ev_if.busy,         e.y);
      end
    end
  end

  initial begin
    logic [3:0] p;
    logic       r;
    int         kind;

    resetn = 1'b0;
    KEY = 4'hF;
    ev_if.event_ready = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    resetn = 1'b1;

    // Clean press of KEY[1]: valid must appear after edge D+1, not before.
    drive(4'b1101, 1'b0, 4);
    chk("press_busy_e3", ev_if.busy, 1);
    drive(4'b1101, 1'b0, 1);
    chk("press_valid_e4", ev_if.event_valid, 0);
    drive(4'b1101, 1'b0, 1);
    chk("press_valid_e5", ev_if.event_valid, 1);
    chk("press_button", ev_if.event_button, 1);
    drive(4'b1101, 1'b0, 100);
    chk("hold_valid", ev_if.event_valid, 1);
    drive(4'b1101, 1'b1, 1);
    chk("accept_valid", ev_if.event_valid, 0);
    drive(4'hF, 1'b0, 5);
    chk("release_busy_e4", ev_if.busy, 1);
    drive(4'hF, 1'b0, 1);
    chk("release_busy_e5", ev_if.busy, 0);
    chk("release_button_held", ev_if.event_button, 1);

    // Glitch shorter than the debounce window.
    drive(4'b1110, 1'b0, 2);
    drive(4'hF, 1'b0, 8);
    chk("glitch_valid", ev_if.event_valid, 0);
    chk("glitch_busy", ev_if.busy, 0);

    // Overrun: KEY[2] left pending, then KEY[3] confirmed and dropped.
    drive(4'b1011, 1'b0, 8);
    drive(4'hF, 1'b0, 8);
    drive(4'b0111, 1'b0, 6);
    chk("overrun_pulse", ev_if.overrun, 1);
    chk("overrun_button", ev_if.event_button, 2);
    drive(4'b0111, 1'b0, 1);
    chk("overrun_one_cycle", ev_if.overrun, 0);
    drive(4'b0111, 1'b1, 1);
    chk("overrun_accept", ev_if.event_valid, 0);
    drive(4'hF, 1'b0, 8);

    // Invalid two-key pattern, then a press with a one-sample bounce while releasing.
    drive(4'b1100, 1'b0, 10);
    chk("invalid_valid", ev_if.event_valid, 0);
    chk("invalid_busy", ev_if.busy, 0);
    drive(4'hF, 1'b0, 3);
    drive(4'b1110, 1'b1, 8);
    drive(4'hF, 1'b0, 3);
    drive(4'b1110, 1'b0, 1);
    drive(4'hF, 1'b0, 8);
    chk("bounce_valid", ev_if.event_valid, 0);

    // Asynchronous reset mid-arming and with an event pending.
    drive(4'b1101, 1'b0, 3);
    async_reset("rst_arming");
    drive(4'hF, 1'b0, 4);
    drive(4'b1110, 1'b0, 8);
    chk("pending_before_rst", ev_if.event_valid, 1);
    async_reset("rst_pending");
    drive(4'hF, 1'b0, 20);
    chk("after_rst_valid", ev_if.event_valid, 0);

    // Randomised segments of idle, single-key, and multi-key patterns.
    for (int s = 0; s < 80; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        p = 4'hF;
      end else if (kind < 8) begin
        p = 4'hF;
        p[$urandom_range(0, 3)] = 1'b0;
      end else begin
        do p = 4'($urandom); while (nzero(p) < 2);
      end
      r = ($urandom_range(0, 3) == 0);
      drive(p, r, $urandom_range(1, 12));
    end
    drive(4'hF, 1'b1, 10);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
